// File: rtl/branch_hazard_unit_if.sv
// branch_hazard_unit_if
//   Bundles the decode/execute hazard signals of the branch hazard unit.
//   master : pipeline side, drives ID/EX status, receives control outputs.
//   slave  : hazard unit side.
//   Signals:
//     ID_valid, ID_isBranch, ID_isJump, ID_branchTaken   ID instruction status
//     ID_PCplus1, ID_offset, ID_jumpTarget [15:0]       target operands
//     ID_rs, ID_rt [3:0]                                ID source registers
//     EX_memRead, EX_regWrite, EX_rd [3:0]              EX instruction status
//     ID_PC [15:0], ID_HazardControl                     registered redirect
//     pcWrite, IFID_write, IFID_flush, IDEX_bubble       pipeline control
//     hazState [1:0]                                     FSM state
//     stallCount, redirectCount [15:0]                   only with HAZARD_STATS_EN
interface branch_hazard_unit_if;
    logic        ID_valid;
    logic        ID_isBranch;
    logic        ID_isJump;
    logic        ID_branchTaken;
    logic [15:0] ID_PCplus1;
    logic [15:0] ID_offset;
    logic [15:0] ID_jumpTarget;
    logic [3:0]  ID_rs;
    logic [3:0]  ID_rt;
    logic        EX_memRead;
    logic        EX_regWrite;
    logic [3:0]  EX_rd;
    logic [15:0] ID_PC;
    logic        ID_HazardControl;
    logic        pcWrite;
    logic        IFID_write;
    logic        IFID_flush;
    logic        IDEX_bubble;
    logic [1:0]  hazState;
`ifdef HAZARD_STATS_EN
    logic [15:0] stallCount;
    logic [15:0] redirectCount;
`endif

    modport master (
        output ID_valid, ID_isBranch, ID_isJump, ID_branchTaken,
               ID_PCplus1, ID_offset, ID_jumpTarget, ID_rs, ID_rt,
               EX_memRead, EX_regWrite, EX_rd,
        input  ID_PC, ID_HazardControl, pcWrite, IFID_write,
               IFID_flush, IDEX_bubble, hazState
`ifdef HAZARD_STATS_EN
        , input stallCount, redirectCount
`endif
    );

    modport slave (
        input  ID_valid, ID_isBranch, ID_isJump, ID_branchTaken,
               ID_PCplus1, ID_offset, ID_jumpTarget, ID_rs, ID_rt,
               EX_memRead, EX_regWrite, EX_rd,
        output ID_PC, ID_HazardControl, pcWrite, IFID_write,
               IFID_flush, IDEX_bubble, hazState
`ifdef HAZARD_STATS_EN
        , output stallCount, redirectCount
`endif
    );
endinterface

// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit
//   Detects load-use and branch operand hazards in ID, stalls the front end,
//   and redirects the PC for taken branches and jumps resolved in ID.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    branch_hazard_unit_if.slave (see interface file for signals)
//   Optional: define HAZARD_STATS_EN to add saturating stallCount and
//   redirectCount statistics outputs on the interface.
module branch_hazard_unit (
    input  logic                        clk,
    input  logic                        rst_n,
    branch_hazard_unit_if.slave         bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        dep, is_ctrl, take, stall, flush, enter_redirect;
    logic [15:0] target;

    always_comb begin
        is_ctrl = bus.ID_isBranch | bus.ID_isJump;
        dep     = bus.ID_valid && (bus.EX_rd != '0) &&
                  ((bus.EX_rd == bus.ID_rs) || (bus.EX_rd == bus.ID_rt));
        take    = bus.ID_valid && (bus.ID_isJump || (bus.ID_isBranch && bus.ID_branchTaken));
        // Jump takes priority when both flags are set; branch sum wraps mod 2^16.
        target  = bus.ID_isJump ? bus.ID_jumpTarget : (bus.ID_PCplus1 + bus.ID_offset);
    end

    always_comb begin
        state_next = RUN;
        stall      = 1'b0;
        flush      = 1'b0;
        case (state)
            RUN: begin
                if (dep && bus.EX_memRead && !is_ctrl) begin
                    stall = 1'b1;
                end else if (dep && is_ctrl && bus.EX_memRead) begin
                    // Loaded value is not ready for the ID comparator until
                    // two cycles later: hold one more cycle in STALL.
                    stall      = 1'b1;
                    state_next = STALL;
                end else if (dep && is_ctrl && bus.EX_regWrite) begin
                    stall = 1'b1;
                end else if (take) begin
                    state_next = REDIRECT;
                end
            end
            STALL:    stall = 1'b1;
            REDIRECT: flush = 1'b1;
            default:  ;
        endcase
        // Reset holds the pipeline running regardless of hazard inputs.
        if (!rst_n) begin
            stall      = 1'b0;
            flush      = 1'b0;
            state_next = RUN;
        end
        enter_redirect  = (state_next == REDIRECT);
        bus.pcWrite     = !stall;
        bus.IFID_write  = !stall;
        bus.IFID_flush  = flush;
        bus.IDEX_bubble = stall | flush;
        bus.hazState    = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ID_PC            <= '0;
            bus.ID_HazardControl <= 1'b0;
        end else begin
            bus.ID_HazardControl <= enter_redirect;
            if (enter_redirect) begin
                bus.ID_PC <= target;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.stallCount    <= '0;
            bus.redirectCount <= '0;
        end else begin
            if (stall && (bus.stallCount != '1)) begin
                bus.stallCount <= bus.stallCount + 16'd1;
            end
            if (enter_redirect && (bus.redirectCount != '1)) begin
                bus.redirectCount <= bus.redirectCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// tb_branch_hazard_unit
//   Self-checking bench for branch_hazard_unit: directed scenarios with literal
//   expectations followed by randomized traffic compared every cycle against
//   a behavioural model. Honours HAZARD_STATS_EN for the statistics outputs.
module tb_branch_hazard_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    branch_hazard_unit_if bus();

    branch_hazard_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: pending extra stall cycle, redirect-in-progress flag,
    // last redirect target and redirect-control flag.
    bit          m_stall_pending;
    bit          m_in_redirect;
    logic [15:0] m_pc;
    bit          m_hc;
    bit          e_stall, e_flush, go_stall, go_redirect;
    logic [15:0] go_target;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.ID_valid       = 1'b0;
        bus.ID_isBranch    = 1'b0;
        bus.ID_isJump      = 1'b0;
        bus.ID_branchTaken = 1'b0;
        bus.ID_PCplus1     = '0;
        bus.ID_offset      = '0;
        bus.ID_jumpTarget  = '0;
        bus.ID_rs          = '0;
        bus.ID_rt          = '0;
        bus.EX_memRead     = 1'b0;
        bus.EX_regWrite    = 1'b0;
        bus.EX_rd          = '0;
    endtask

    task automatic model_eval();
        bit ctrl, dep;
        int sum;
        e_stall     = 1'b0;
        e_flush     = 1'b0;
        go_stall    = 1'b0;
        go_redirect = 1'b0;
        go_target   = '0;
        if (!rst_n) begin
            m_stall_pending = 1'b0;
            m_in_redirect   = 1'b0;
            m_pc            = '0;
            m_hc            = 1'b0;
        end else if (m_in_redirect) begin
            e_flush = 1'b1;
        end else if (m_stall_pending) begin
            e_stall = 1'b1;
        end else begin
            ctrl = bus.ID_isJump || bus.ID_isBranch;
            dep  = bus.ID_valid && (bus.EX_rd != 0) &&
                   (bus.EX_rd == bus.ID_rs || bus.EX_rd == bus.ID_rt);
            if (dep && (bus.EX_memRead || (ctrl && bus.EX_regWrite))) begin
                e_stall  = 1'b1;
                go_stall = ctrl && bus.EX_memRead;
            end else if (bus.ID_valid && (bus.ID_isJump || (bus.ID_isBranch && bus.ID_branchTaken))) begin
                go_redirect = 1'b1;
                sum = (int'(bus.ID_PCplus1) + int'(bus.ID_offset)) % 65536;
                go_target = bus.ID_isJump ? bus.ID_jumpTarget : 16'(sum);
            end
        end
    endtask

    task automatic compare();
        chk("pcWrite",          bus.pcWrite,          !e_stall);
        chk("IFID_write",       bus.IFID_write,       !e_stall);
        chk("IFID_flush",       bus.IFID_flush,       e_flush);
        chk("IDEX_bubble",      bus.IDEX_bubble,      e_stall | e_flush);
        chk("hazState",         bus.hazState,         m_in_redirect ? 2 : (m_stall_pending ? 1 : 0));
        chk("ID_PC",            bus.ID_PC,            m_pc);
        chk("ID_HazardControl", bus.ID_HazardControl, m_hc);
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            m_stall_pending = 1'b0;
            m_in_redirect   = 1'b0;
            m_pc            = '0;
            m_hc            = 1'b0;
        end else begin
            m_hc            = go_redirect;
            m_in_redirect   = go_redirect;
            m_stall_pending = go_stall;
            if (go_redirect) m_pc = go_target;
        end
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        #1;
        model_eval();
        compare();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic branch(input logic [15:0] pcp1, input logic [15:0] off);
        idle();
        bus.ID_valid       = 1'b1;
        bus.ID_isBranch    = 1'b1;
        bus.ID_branchTaken = 1'b1;
        bus.ID_PCplus1     = pcp1;
        bus.ID_offset      = off;
        bus.ID_rs          = 4'd1;
        bus.ID_rt          = 4'd2;
    endtask

    initial begin
        idle();
        m_stall_pending = 1'b0;
        m_in_redirect   = 1'b0;
        m_pc            = '0;
        m_hc            = 1'b0;

        // Reset state with hazard-looking inputs present.
        #2 rst_n = 1'b0;
        bus.ID_valid = 1'b1; bus.ID_rs = 4'd3; bus.EX_rd = 4'd3; bus.EX_memRead = 1'b1;
        #1;
        chk("rst_ID_PC",   bus.ID_PC, 16'h0000);
        chk("rst_HC",      bus.ID_HazardControl, 1'b0);
        chk("rst_state",   bus.hazState, 2'd0);
        chk("rst_pcWrite", bus.pcWrite, 1'b1);
        chk("rst_bubble",  bus.IDEX_bubble, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();

        // Taken branch with negative offset, one-cycle redirect.
        branch(16'h0010, 16'hFFF8);
        step();
        chk("br_ID_PC",  bus.ID_PC, 16'h0008);
        chk("br_HC",     bus.ID_HazardControl, 1'b1);
        chk("br_flush",  bus.IFID_flush, 1'b1);
        chk("br_bubble", bus.IDEX_bubble, 1'b1);
        chk("br_state",  bus.hazState, 2'd2);
        idle();
        step();
        chk("br_after_flush", bus.IFID_flush, 1'b0);
        chk("br_after_HC",    bus.ID_HazardControl, 1'b0);
        chk("br_after_ID_PC", bus.ID_PC, 16'h0008);

        // Branch target wraps around 16 bits.
        branch(16'hFFFF, 16'h0003);
        step();
        chk("wrap_ID_PC", bus.ID_PC, 16'h0002);
        idle();
        step();

        // Load-use on rs, then the same with EX_rd = 0.
        bus.ID_valid = 1'b1; bus.ID_rs = 4'd3; bus.EX_memRead = 1'b1; bus.EX_rd = 4'd3;
        #1;
        chk("lu_pcWrite", bus.pcWrite, 1'b0);
        chk("lu_bubble",  bus.IDEX_bubble, 1'b1);
        step();
        chk("lu_state", bus.hazState, 2'd0);
        bus.EX_rd = 4'd0;
        #1;
        chk("lu_r0_pcWrite", bus.pcWrite, 1'b1);
        step();

        // Jump presented during REDIRECT is ignored.
        idle();
        bus.ID_valid = 1'b1; bus.ID_isJump = 1'b1; bus.ID_jumpTarget = 16'h1234;
        step();
        chk("jmp_ID_PC", bus.ID_PC, 16'h1234);
        bus.ID_jumpTarget = 16'hABCD;
        step();
        chk("jmp_ign_ID_PC", bus.ID_PC, 16'h1234);
        chk("jmp_ign_state", bus.hazState, 2'd0);
        chk("jmp_ign_HC",    bus.ID_HazardControl, 1'b0);
        idle();
        step();

        // Asynchronous reset while in REDIRECT.
        branch(16'h0010, 16'hFFF8);
        step();
        chk("ar_pre_ID_PC", bus.ID_PC, 16'h0008);
        idle();
        rst_n = 1'b0;
        #1;
        chk("ar_ID_PC", bus.ID_PC, 16'h0000);
        chk("ar_HC",    bus.ID_HazardControl, 1'b0);
        chk("ar_state", bus.hazState, 2'd0);
        chk("ar_flush", bus.IFID_flush, 1'b0);
        step();
        rst_n = 1'b1;

        // Branch depending on a load: two stall cycles then redirect.
        branch(16'h0100, 16'h0020);
        bus.ID_rt = 4'd5; bus.EX_memRead = 1'b1; bus.EX_rd = 4'd5;
        #1;
        chk("bl_c1_pcWrite", bus.pcWrite, 1'b0);
        chk("bl_c1_state",   bus.hazState, 2'd0);
        step();
        chk("bl_c2_pcWrite", bus.pcWrite, 1'b0);
        chk("bl_c2_state",   bus.hazState, 2'd1);
        bus.EX_memRead = 1'b0; bus.EX_rd = 4'd0;
        step();
        chk("bl_c3_pcWrite", bus.pcWrite, 1'b1);
        chk("bl_c3_state",   bus.hazState, 2'd0);
        step();
        chk("bl_ID_PC", bus.ID_PC, 16'h0120);
        chk("bl_state", bus.hazState, 2'd2);
`ifdef HAZARD_STATS_EN
        chk("stallCount",    bus.stallCount, 16'd2);
        chk("redirectCount", bus.redirectCount, 16'd1);
`endif
        idle();
        step();

        // Randomized traffic biased toward register collisions.
        for (int i = 0; i < 3000; i++) begin
            rst_n              = ($urandom_range(0, 59) != 0);
            bus.ID_valid       = ($urandom_range(0, 9) < 8);
            bus.ID_isBranch    = ($urandom_range(0, 9) < 3);
            bus.ID_isJump      = ($urandom_range(0, 9) < 2);
            bus.ID_branchTaken = $urandom_range(0, 1) == 1;
            bus.ID_PCplus1     = 16'($urandom);
            bus.ID_offset      = 16'($urandom);
            bus.ID_jumpTarget  = 16'($urandom);
            bus.ID_rs          = 4'($urandom_range(0, 7));
            bus.ID_rt          = 4'($urandom_range(0, 7));
            bus.EX_memRead     = ($urandom_range(0, 9) < 3);
            bus.EX_regWrite    = $urandom_range(0, 1) == 1;
            bus.EX_rd          = 4'($urandom_range(0, 7));
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_hazard_unit.md
BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 ID_valid  in  1  ID stage holds a real instruction.
REQ-004 ID_isBranch  in  1  ID instruction is a conditional branch.
REQ-005 ID_isJump  in  1  ID instruction is an unconditional jump.
REQ-006 ID_branchTaken  in  1  ID comparator result, meaningful when ID_isBranch=1.
REQ-007 ID_PCplus1  in  16  address following the ID instruction.
REQ-008 ID_offset  in  16  sign-extended branch offset.
REQ-009 ID_jumpTarget  in  16  absolute jump target.
REQ-010 ID_rs  in  4  ID source register 1.
REQ-011 ID_rt  in  4  ID source register 2.
REQ-012 EX_memRead  in  1  EX instruction is a load.
REQ-013 EX_regWrite  in  1  EX instruction writes a register.
REQ-014 EX_rd  in  4  EX destination register.
REQ-015 ID_PC  out  16  registered redirect target sent to the PC source mux.
REQ-016 ID_HazardControl  out  1  registered; 1 selects ID_PC as next PC.
REQ-017 pcWrite  out  1  PC register enable.
REQ-018 IFID_write  out  1  IF/ID register enable.
REQ-019 IFID_flush  out  1  clear IF/ID register.
REQ-020 IDEX_bubble  out  1  insert NOP into ID/EX.
REQ-021 hazState  out  2  FSM state: RUN=0, STALL=1, REDIRECT=2.

Function
REQ-022 dep = ID_valid, EX_rd!=0, and EX_rd equal to ID_rs or ID_rt.
REQ-023 Load-use: RUN, dep, EX_memRead=1, not branch/jump -> same-cycle stall (pcWrite=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0); state stays RUN.
REQ-024 Branch/jump with dep and EX_regWrite=1, EX_memRead=0 -> one comb stall cycle; state stays RUN; no redirect that cycle.
REQ-025 Branch/jump with dep and EX_memRead=1 -> comb stall this cycle, next state STALL; STALL asserts stall outputs one cycle, then RUN; branch re-evaluated in RUN (two stall cycles total).
REQ-026 Redirect: RUN, no stall, ID_valid, (ID_isJump or ID_isBranch&ID_branchTaken) -> next edge ID_PC<=target, ID_HazardControl<=1, state REDIRECT.
REQ-027 Target: jump -> ID_jumpTarget; branch -> (ID_PCplus1+ID_offset) mod 2^16, carry discarded; jump wins if both flags set.
REQ-028 REDIRECT lasts exactly one cycle: IFID_flush=1, IDEX_bubble=1, pcWrite=1, IFID_write=1; all ID inputs ignored; then RUN, ID_HazardControl<=0.
REQ-029 ID_PC holds its last target after REDIRECT; only ID_HazardControl deasserts.
REQ-030 RUN with no hazard/redirect: pcWrite=1, IFID_write=1, IFID_flush=0, IDEX_bubble=0.
REQ-031 ID_valid=0 never produces a stall or redirect.
REQ-032 Unused encoding 3 -> RUN on next edge, outputs as RUN.

Reset
REQ-033 rst_n=0 immediately forces ID_PC=0x0000, ID_HazardControl=0, hazState=RUN, regardless of state, including mid-STALL/REDIRECT.
REQ-034 While rst_n=0: pcWrite=1, IFID_write=1, IFID_flush=0, IDEX_bubble=0.
REQ-035 First edge after rst_n rises evaluates from RUN.

Configuration
REQ-036 HAZARD_STATS_EN defined: adds outputs stallCount[15:0] (+1 per stall-output cycle) and redirectCount[15:0] (+1 per REDIRECT entry); both saturate at 0xFFFF, reset to 0.
REQ-037 HAZARD_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-038 Pulse rst_n=0 while in REDIRECT with ID_PC=0x0008 -> ID_PC=0x0000, ID_HazardControl=0, hazState=0 without a clock edge.
REQ-039 Taken branch, ID_PCplus1=0x0010, ID_offset=0xFFF8 -> next cycle ID_PC=0x0008, ID_HazardControl=1, IFID_flush=1, IDEX_bubble=1 for exactly one cycle.
REQ-040 Branch wrap, ID_PCplus1=0xFFFF, ID_offset=0x0003 -> ID_PC=0x0002.
REQ-041 Load-use, EX_memRead=1, EX_rd=3, ID_rs=3, non-branch -> one cycle pcWrite=0; repeat with EX_rd=0 -> no stall.
REQ-042 Taken branch, ID_rt=5, EX_memRead=1, EX_rd=5 -> two stall cycles, then redirect; with HAZARD_STATS_EN stallCount=2, redirectCount=1.
REQ-043 Jump presented during REDIRECT -> ignored; ID_PC unchanged, state returns to RUN.
